// File: rtl/pipe_stage_elastic.sv
// ============================================================================
// Module   : pipe_stage_elastic
// Purpose  : Elastic valid/ready pipeline register carrying a control and a
//            data bundle; control is zeroed on every bubble. Define macro
//            PIPE_STAGE_SKID_EN to add a second (skid) entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_elastic #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 96
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic in_xfer;
   logic out_xfer;

`ifdef PIPE_STAGE_SKID_EN
   // State encoding equals the entry count, so occupancy reads the state directly.
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d, skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;

   assign in_xfer  = in_valid & in_ready_q;
   assign out_xfer = (state_q != S_EMPTY) & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_EMPTY;
         in_ready_q  <= 1'b1;
         head_ctrl_q <= '0;
         head_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         head_ctrl_q <= head_ctrl_d;
         head_data_q <= head_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: if (in_xfer) state_d = S_ONE;
            S_ONE: begin
               if (in_xfer && !out_xfer)      state_d = S_TWO;
               else if (!in_xfer && out_xfer) state_d = S_EMPTY;
            end
            S_TWO:   if (out_xfer) state_d = S_ONE;
            default: state_d = S_EMPTY;
         endcase
      end
      // Registered ready: decided from the next state, never from out_ready.
      in_ready_d = (state_d != S_TWO);
   end

   // Storage is cleared whenever an entry leaves, keeping out_* zero on bubbles.
   always_comb begin
      head_ctrl_d = head_ctrl_q;
      head_data_d = head_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         head_ctrl_d = '0;
         head_data_d = '0;
         skid_ctrl_d = '0;
         skid_data_d = '0;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_xfer) begin
                  head_ctrl_d = in_ctrl;
                  head_data_d = in_data;
               end
            end
            S_ONE: begin
               if (in_xfer && out_xfer) begin
                  head_ctrl_d = in_ctrl;
                  head_data_d = in_data;
               end else if (in_xfer) begin
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
               end else if (out_xfer) begin
                  head_ctrl_d = '0;
                  head_data_d = '0;
               end
            end
            S_TWO: begin
               if (out_xfer) begin
                  head_ctrl_d = skid_ctrl_q;
                  head_data_d = skid_data_q;
                  skid_ctrl_d = '0;
                  skid_data_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      out_valid = (state_q != S_EMPTY);
      in_ready  = in_ready_q;
      occupancy = state_q;
      out_ctrl  = head_ctrl_q;
      out_data  = head_data_q;
   end

`else
   localparam logic S_EMPTY = 1'b0;
   localparam logic S_FULL  = 1'b1;

   logic              state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] data_q, data_d;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = (state_q == S_FULL) & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_EMPTY;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: if (in_xfer) state_d = S_FULL;
            S_FULL:  if (out_xfer && !in_xfer) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
         endcase
      end
   end

   always_comb begin
      ctrl_d = ctrl_q;
      data_d = data_q;
      if (flush) begin
         ctrl_d = '0;
         data_d = '0;
      end else if (in_xfer) begin
         ctrl_d = in_ctrl;
         data_d = in_data;
      end else if (out_xfer) begin
         ctrl_d = '0;
         data_d = '0;
      end
   end

   always_comb begin
      out_valid = (state_q == S_FULL);
      in_ready  = !out_valid | out_ready;
      occupancy = {1'b0, state_q};
      out_ctrl  = ctrl_q;
      out_data  = data_q;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: accepted inputs are queued, the
// monitor compares every output cycle against the queue head (zeros when empty).
`default_nettype none

module tb_pipe_stage_elastic;

`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_ctrl;
   logic [95:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_ctrl;
   logic [95:0] out_data;
   logic [1:0]  occupancy;

   logic [103:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   pipe_stage_elastic #(.CTRL_W(8), .DATA_W(96)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: model state is the queue as of the last clock edge.
   always @(negedge clk) begin
      int          sz;
      logic [7:0]  ec;
      logic [95:0] ed;
      sz = exp_q.size();
      if (sz > 0) {ec, ed} = exp_q[0];
      else begin
         ec = '0;
         ed = '0;
      end
      chk("occupancy", {126'd0, occupancy}, 128'(sz));
      chk("out_valid", {127'd0, out_valid}, {127'd0, sz > 0});
      chk("out_ctrl", {120'd0, out_ctrl}, {120'd0, ec});
      chk("out_data", {32'd0, out_data}, {32'd0, ed});
      if (!flush)
         chk("in_ready", {127'd0, in_ready},
             {127'd0, (CAP == 2) ? (sz < 2) : (sz == 0 || out_ready)});
      if (!reset && !flush && out_valid && out_ready && sz > 0)
         void'(exp_q.pop_front());
   end

   // One cycle of stimulus; inputs change just after the rising edge.
   task automatic step(input bit iv, input logic [7:0] c, input logic [95:0] d,
                       input bit ordy, input bit fl);
      @(posedge clk);
      #1;
      in_valid  = iv;
      in_ctrl   = c;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      #1;
      if (!reset) begin
         if (flush) exp_q.delete();
         else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
      end
   endtask

   function automatic logic [95:0] rnd96();
      logic [95:0] v;
      v = {$urandom, $urandom, $urandom};
      return v;
   endfunction

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_ctrl   = '0;
      in_data   = '0;
      out_ready = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #1;
      chk("post_reset_in_ready", {127'd0, in_ready}, 128'd1);

      // Back-to-back stream with full throughput.
      for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 96'(i * 16), 1'b1, 1'b0);
      step(1'b0, 8'h00, 96'd0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 96'd0, 1'b1, 1'b0);

      // Stall: held entry stays stable, second item goes to skid if present.
      step(1'b1, 8'hA5, 96'h1234, 1'b1, 1'b0);
      step(1'b1, 8'h5A, 96'h5678, 1'b0, 1'b0);
      step(1'b1, 8'h5B, 96'h9ABC, 1'b0, 1'b0);
      step(1'b1, 8'h5C, 96'hDEF0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 8'h00, 96'd0, 1'b1, 1'b0);

      // Flush with a held entry and a simultaneous input.
      step(1'b1, 8'h11, 96'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 96'h22, 1'b0, 1'b0);
      step(1'b1, 8'h77, 96'h77, 1'b0, 1'b1);
      step(1'b0, 8'h00, 96'd0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 96'd0, 1'b1, 1'b0);

      // Fill with A then B under stall, then drain in order.
      step(1'b1, 8'hAA, 96'hAAAA, 1'b0, 1'b0);
      step(1'b1, 8'hBB, 96'hBBBB, 1'b0, 1'b0);
      step(1'b0, 8'h00, 96'd0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 8'h00, 96'd0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a pending transfer.
      step(1'b1, 8'hC3, 96'hC3C3, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_ctrl   = 8'hEE;
      in_data   = 96'hEEEE;
      out_ready = 1'b1;
      #2 reset = 1'b1;
      exp_q.delete();
      #1;
      chk("async_rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("async_rst_occupancy", {126'd0, occupancy}, 128'd0);
      chk("async_rst_out_ctrl", {120'd0, out_ctrl}, 128'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_reset_in_ready", {127'd0, in_ready}, 128'd1);

      // Random traffic.
      for (int i = 0; i < 10000; i++)
         step($urandom_range(0, 99) < 70, 8'($urandom), rnd96(),
              $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 3);

      step(1'b0, 8'h00, 96'd0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 96'd0, 1'b1, 1'b0);
      @(negedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
